hamming_fitness: RTL and testbench

- Fitness responder for the GA engine's fitness handshake (start / individual -> finish / error).
- A drop-in alternative to the morphologic evaluator, for bit-string target problems.
- Error is the Hamming distance between the individual and a target word, computed serially, ChunkWidth bits per cycle, to bound adder depth.
- Sits beside the GA engine in a top-level wrapper, driven by the engine's fitness start/individual outputs.

---
 rtl/hamming_fitness.sv | 118 +++++++++++
 tb/tb_hamming_fitness.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hamming_fitness.sv
// Serial Hamming-distance fitness responder for the GA engine handshake.
// Optional build macro HAMMING_FITNESS_MASK_EN adds a per-bit don't-care mask input.
module hamming_fitness #(
   parameter int unsigned IndividualWidth = 64,
   parameter int unsigned ChunkWidth      = 8,
   parameter int unsigned ErrorWidth      = $clog2(IndividualWidth + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [IndividualWidth-1:0] individual,
   input  logic [IndividualWidth-1:0] objetive,
`ifdef HAMMING_FITNESS_MASK_EN
   input  logic [IndividualWidth-1:0] mask,
`endif
   output logic                       finish,
   output logic [ErrorWidth-1:0]      error,
   output logic                       busy
);

   localparam int unsigned NumChunks = IndividualWidth / ChunkWidth;
   localparam int unsigned CntWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
   localparam int unsigned AccWidth  = ErrorWidth + 1;
   localparam int unsigned PopWidth  = $clog2(ChunkWidth + 1);
   localparam logic [AccWidth-1:0] ErrMax = {1'b0, {ErrorWidth{1'b1}}};
   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumChunks - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                     r_state;
   logic [IndividualWidth-1:0] r_ind;
   logic [IndividualWidth-1:0] r_tgt;
`ifdef HAMMING_FITNESS_MASK_EN
   logic [IndividualWidth-1:0] r_mask;
`endif
   logic [AccWidth-1:0]        r_acc;
   logic [CntWidth-1:0]        r_cnt;
   logic [ChunkWidth-1:0]      w_chunk;
   logic [PopWidth-1:0]        w_pop;
   logic [ErrorWidth-1:0]      w_err_sat;

   // Mismatch bits of the chunk currently at the bottom of the shift registers
`ifdef HAMMING_FITNESS_MASK_EN
   assign w_chunk = (r_ind[ChunkWidth-1:0] ^ r_tgt[ChunkWidth-1:0]) & r_mask[ChunkWidth-1:0];
`else
   assign w_chunk = r_ind[ChunkWidth-1:0] ^ r_tgt[ChunkWidth-1:0];
`endif

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < int'(ChunkWidth); i++) begin
         w_pop = w_pop + PopWidth'(w_chunk[i]);
      end
   end

   // Saturation only bites when ErrorWidth is overridden narrower than needed
   assign w_err_sat = (r_acc > ErrMax) ? ErrorWidth'(ErrMax) : r_acc[ErrorWidth-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_ind   <= '0;
         r_tgt   <= '0;
`ifdef HAMMING_FITNESS_MASK_EN
         r_mask  <= '0;
`endif
         r_acc   <= '0;
         r_cnt   <= '0;
         finish  <= 1'b0;
         error   <= '0;
         busy    <= 1'b0;
      end else begin
         finish <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ind   <= individual;
                  r_tgt   <= objetive;
`ifdef HAMMING_FITNESS_MASK_EN
                  r_mask  <= mask;
`endif
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= r_acc + AccWidth'(w_pop);
               r_ind <= r_ind >> ChunkWidth;
               r_tgt <= r_tgt >> ChunkWidth;
`ifdef HAMMING_FITNESS_MASK_EN
               r_mask <= r_mask >> ChunkWidth;
`endif
               r_cnt <= r_cnt + CntWidth'(1);
               if (r_cnt == LastCnt) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               error   <= w_err_sat;
               finish  <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_fitness.sv
// Directed self-checking bench for hamming_fitness (default 64-bit, 8-bit chunks).
module tb_hamming_fitness;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] individual = '0;
   logic [63:0] objetive = '0;
`ifdef HAMMING_FITNESS_MASK_EN
   logic [63:0] mask = '1;
`endif
   logic        finish;
   logic [6:0]  error;
   logic        busy;

   int checks = 0;
   int errors = 0;

   hamming_fitness dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .individual (individual),
      .objetive   (objetive),
`ifdef HAMMING_FITNESS_MASK_EN
      .mask       (mask),
`endif
      .finish     (finish),
      .error      (error),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Ticks until finish rises; returns edges counted since the start edge (bounded)
   task automatic wait_finish(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!finish && n < 40);
   endtask

   task automatic run_eval(input string tag, input logic [63:0] ind, input logic [63:0] tgt,
                           input logic [63:0] exp_err);
      int n;
      individual = ind;
      objetive   = tgt;
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      wait_finish(n);
      chk({tag, "_latency"}, 64'(n), 64'd9);
      chk({tag, "_error"}, 64'(error), exp_err);
      chk({tag, "_busy_at_finish"}, 64'(busy), 64'd0);
      tick();
      chk({tag, "_finish_pulse"}, 64'(finish), 64'd0);
   endtask

   initial begin
      int n;
      logic [63:0] base;
      base = 64'h0123_4567_89AB_CDEF;

      #2 rst = 1'b0;
      tick();
      tick();
      chk("reset_finish", 64'(finish), 64'd0);
      chk("reset_error", 64'(error), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_finish", 64'(finish), 64'd0);
         chk("idle_busy", 64'(busy), 64'd0);
         chk("idle_error", 64'(error), 64'd0);
      end

      run_eval("all_diff", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64);
      run_eval("equal", base, base, 64'd0);
      run_eval("flip3", base ^ 64'h8000_0000_8000_0001, base, 64'd3);

      // Inputs change mid-RUN; result must reflect captured values
      individual = base ^ 64'h0000_0100_0000_0010;
      objetive   = base;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      individual = ~base;
      objetive   = 64'h0;
      wait_finish(n);
      chk("midrun_latency", 64'(n + 2), 64'd9);
      chk("midrun_error", 64'(error), 64'd2);

      // Start pulse 3 cycles into RUN is ignored, then back-to-back start at finish
      tick();
      individual = 64'hFF;
      objetive   = 64'h0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      start = 1'b1;
      individual = 64'hFFFF;
      tick();
      start = 1'b0;
      wait_finish(n);
      chk("ignored_latency", 64'(n + 4), 64'd9);
      chk("ignored_error", 64'(error), 64'd8);
      individual = 64'hF;
      objetive   = 64'h0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_no_second_pulse", 64'(finish), 64'd0);
      wait_finish(n);
      chk("b2b_latency", 64'(n), 64'd9);
      chk("b2b_error", 64'(error), 64'd4);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("b2b_quiet", 64'(finish), 64'd0);
      end

      // Reset during RUN aborts with no finish
      individual = 64'h0;
      objetive   = 64'h3;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b0;
      #1;
      chk("abort_finish", 64'(finish), 64'd0);
      chk("abort_error", 64'(error), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      tick();
      rst = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (finish) seen++;
         end
         chk("abort_no_finish", 64'(seen), 64'd0);
      end
      chk("abort_error_hold", 64'(error), 64'd0);
      run_eval("after_abort", 64'hFF, 64'h0, 64'd8);

`ifdef HAMMING_FITNESS_MASK_EN
      mask = 64'h0000_0000_0000_00FF;
      run_eval("mask_ff", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd8);
      mask = 64'h0;
      run_eval("mask_zero", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      mask = '1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
